// File: rtl/alu_pkg.sv
// Shared definitions for the ALU dispatcher: opcodes, instruction field
// positions, FSM state encoding and a small opcode-class helper.
package alu_pkg;

  // Opcodes carried in instr[31:29]
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_TERN = 3'b101;
  localparam logic [2:0] OP_LI   = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  // Instruction field bit positions
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 29;
  localparam int RD_HI  = 28;
  localparam int RD_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 23;
  localparam int RT_HI  = 22;
  localparam int RT_LO  = 20;
  localparam int IMM_HI = 19;
  localparam int IMM_LO = 0;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  // True for opcodes executed by the external ALU (ADD..TERN)
  function automatic logic is_alu_op(input logic [2:0] opc);
    return (opc <= OP_TERN);
  endfunction

endpackage

// File: rtl/alu_dispatch_if.sv
// Instruction handshake plus the ALU operand/result bus of the dispatcher.
// slave: the dispatcher side; master: the environment (upstream + ALU).
interface alu_dispatch_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  op;
  logic [31:0] Res;
  logic        Zflag;

  modport slave (
    input  instr_valid, instr, Res, Zflag,
    output instr_ready, A, B, op
  );

  modport master (
    output instr_valid, instr, Res, Zflag,
    input  instr_ready, A, B, op
  );
endinterface

// File: rtl/alu_dispatch_sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fall-through output.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; simultaneous push and pop leave the count unchanged
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty masks them
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/alu_dispatch.sv
// alu_dispatch: issue stage in front of a 32-bit ALU. Buffers instructions,
// reads operands from an 8x32 register file, drives A/B/op, writes Res back.
// Optional feature macro: ALU_DISPATCH_LI_EN enables the LI (load-immediate)
// opcode; without it opcode 110 is flagged illegal like 111.
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int QDEPTH  = 4,
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  alu_dispatch_if.slave    bus,
  input  logic [2:0]       dbg_addr,
  output logic [31:0]      dbg_data,
  output logic             busy,
  output logic             zflag_last,
  output logic             err,
  output logic [CNT_W-1:0] retired
);
  localparam int WCNT_W = $clog2(ALU_LAT + 1);
`ifdef ALU_DISPATCH_LI_EN
  localparam int IR_LO = IMM_LO;
`else
  // Immediate bits are never needed, so they are not held
  localparam int IR_LO = RT_LO;
`endif

  state_t             state_q, state_d;
  logic [31:IR_LO]    ir_q;
  logic               pend_q;
  logic [WCNT_W-1:0]  wcnt_q;
  logic [31:0]        regs_q [8];
  logic [31:0]        a_q, b_q;
  logic [2:0]         op_q;
  logic               zflag_q;
  logic               err_q;
  logic [CNT_W-1:0]   retired_q;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0]        fifo_dout;
  logic               rf_we;
  logic [2:0]         rf_waddr;
  logic [31:0]        rf_wdata;
  logic               retire_inc;
  logic               err_set;

`ifndef ALU_DISPATCH_LI_EN
  logic unused_imm;
  assign unused_imm = ^fifo_dout[IMM_HI:IMM_LO];
`endif

  assign bus.instr_ready = !fifo_full && !RST;
  assign fifo_push       = bus.instr_valid && bus.instr_ready;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (fifo_push),
    .din   (bus.instr),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  assign bus.A      = a_q;
  assign bus.B      = b_q;
  assign bus.op     = op_q;
  assign dbg_data   = regs_q[dbg_addr];
  // A popped LI/illegal still has work pending in IDLE, so it counts as busy
  assign busy       = (state_q != S_IDLE) || !fifo_empty || pend_q;
  assign zflag_last = zflag_q;
  assign err        = err_q;
  assign retired    = retired_q;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state, FIFO pop and register-file write port
  always_comb begin
    state_d    = state_q;
    fifo_pop   = 1'b0;
    rf_we      = 1'b0;
    rf_waddr   = ir_q[RD_HI:RD_LO];
    rf_wdata   = bus.Res;
    retire_inc = 1'b0;
    err_set    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A non-ALU instruction popped last cycle completes now
        if (pend_q) begin
`ifdef ALU_DISPATCH_LI_EN
          if (ir_q[OP_HI:OP_LO] == OP_LI) begin
            rf_we      = 1'b1;
            rf_wdata   = 32'(ir_q[IMM_HI:IMM_LO]);
            retire_inc = 1'b1;
          end else begin
            err_set = 1'b1;
          end
`else
          err_set = 1'b1;
`endif
        end
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (is_alu_op(fifo_dout[OP_HI:OP_LO])) state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (wcnt_q == WCNT_W'(1)) state_d = S_WB;
      end
      S_WB: begin
        rf_we      = 1'b1;
        retire_inc = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register file; rd may equal rs/rt since operands were latched in ISSUE
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      regs_q[rf_waddr] <= rf_wdata;
    end
  end

  // Instruction register, ALU operand latches, wait counter and status
  always_ff @(posedge CLK) begin
    if (RST) begin
      ir_q      <= '0;
      pend_q    <= 1'b0;
      wcnt_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      zflag_q   <= 1'b0;
      err_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      if (fifo_pop) begin
        ir_q   <= fifo_dout[31:IR_LO];
        pend_q <= !is_alu_op(fifo_dout[OP_HI:OP_LO]);
      end else if (state_q == S_IDLE) begin
        pend_q <= 1'b0;
      end
      if (err_set)    err_q     <= 1'b1;
      if (retire_inc) retired_q <= retired_q + CNT_W'(1);
      case (state_q)
        S_ISSUE: begin
          a_q    <= regs_q[ir_q[RS_HI:RS_LO]];
          b_q    <= regs_q[ir_q[RT_HI:RT_LO]];
          op_q   <= ir_q[OP_HI:OP_LO];
          wcnt_q <= WCNT_W'(ALU_LAT);
        end
        S_WAIT:  wcnt_q  <= wcnt_q - WCNT_W'(1);
        S_WB:    zflag_q <= bus.Zflag;
        default: ;
      endcase
    end
  end

endmodule
